mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Owns the HI/LO architectural registers.
- Sequences MULT/MULTU/DIV/DIVU operations over a fixed latency and raises busy so the hazard unit can stall MF*/MT*/MD instructions.
- Performs single-cycle MTHI/MTLO writes.

---
 rtl/mdu_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer that owns the HI/LO registers.
// The full result is computed at issue and held in pending registers. The
// sequencer then waits out the fixed latency before it commits the result.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic        accept,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    state_e      state_q, state_n;
    logic [31:0] cnt_q, cnt_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;
    logic [31:0] phi_q, phi_n, plo_q, plo_n;
    logic        done_q, done_n;

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag1, mag2, q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Signed divide works on magnitudes and then fixes the signs.
    // 0x80000000 / -1 therefore wraps to 0x80000000 and does not trap.
    always_comb begin
        prod_s = {{32{v1[31]}}, v1} * {{32{v2[31]}}, v2};
        prod_u = {32'b0, v1} * {32'b0, v2};
        mag1   = v1[31] ? -v1 : v1;
        mag2   = v2[31] ? -v2 : v2;
        q_mag  = (mag2 == '0) ? '0 : mag1 / mag2;
        r_mag  = (mag2 == '0) ? '0 : mag1 % mag2;
        q_s    = (v1[31] ^ v2[31]) ? -q_mag : q_mag;
        r_s    = v1[31] ? -r_mag : r_mag;
        q_u    = (v2 == '0) ? '0 : v1 / v2;
        r_u    = (v2 == '0) ? '0 : v1 % v2;
    end

    assign accept = start & (state_q == IDLE) & (op <= 3'd5);
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Next-state logic: issue, countdown and commit.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        phi_n   = phi_q;
        plo_n   = plo_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            phi_n   = prod_s[63:32];
                            plo_n   = prod_s[31:0];
                            cnt_n   = 32'(MULT_LAT - 1);
                            state_n = RUN;
                        end
                        OP_MULTU: begin
                            phi_n   = prod_u[63:32];
                            plo_n   = prod_u[31:0];
                            cnt_n   = 32'(MULT_LAT - 1);
                            state_n = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still runs the full latency and
                            // commits, but it recommits the current HI/LO.
                            if (v2 == '0) begin
                                phi_n = hi_q;
                                plo_n = lo_q;
                            end else if (op == OP_DIV) begin
                                phi_n = r_s;
                                plo_n = q_s;
                            end else begin
                                phi_n = r_u;
                                plo_n = q_u;
                            end
                            cnt_n   = 32'(DIV_LAT - 1);
                            state_n = RUN;
                        end
                        OP_MTHI: hi_n = v1;
                        OP_MTLO: lo_n = v1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 32'd1;
                end else begin
                    hi_n    = phi_q;
                    lo_n    = plo_q;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            phi_q   <= phi_n;
            plo_q   <= plo_n;
            done_q  <= done_n;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with a behavioural HI/LO model.
module tb_mdu_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        accept;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;

    mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .v1(v1), .v2(v2),
        .accept(accept), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one op applied to the current HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] ch,
                                  input logic [31:0] cl, output logic [31:0] eh,
                                  output logic [31:0] el);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        eh = ch;
        el = cl;
        case (o)
            3'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            3'd1: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0];
            end
            3'd3: if (b != 0) begin
                up = ua / ub; eh = up[31:0]; up = ua % ub; el = eh; eh = up[31:0];
                up = ua / ub; el = up[31:0];
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endfunction

    // Issue one op from idle and follow it through to its commit.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el, oh, ol;
        int lat, nb;
        logic eacc, edone;
        model(o, a, b, mh, ml, eh, el);
        eacc  = (o <= 3'd5);
        lat   = (o <= 3'd1) ? ML : (o <= 3'd3) ? DL : 0;
        edone = (o <= 3'd3);
        if (!eacc) begin eh = mh; el = ml; end
        oh = mh;
        ol = ml;
        @(negedge clk);
        start = 1'b1; op = o; v1 = a; v2 = b;
        #1;
        tests++;
        if (accept !== eacc) begin
            fails++; $display("FAIL accept op=%0d: got %b expected %b", o, accept, eacc);
        end
        @(negedge clk);
        start = 1'b0; v1 = $urandom; v2 = $urandom;
        nb = 0;
        while (busy === 1'b1 && nb < lat + 4) begin
            nb++;
            tests++;
            if (hi !== oh || lo !== ol || done !== 1'b0) begin
                fails++;
                $display("FAIL run_hold op=%0d: got hi=%h lo=%h done=%b expected hi=%h lo=%h done=0",
                         o, hi, lo, done, oh, ol);
            end
            @(negedge clk);
        end
        tests++;
        if (nb != lat || busy !== 1'b0) begin
            fails++; $display("FAIL busy_len op=%0d: got %0d expected %0d", o, nb, lat);
        end
        tests++;
        if (hi !== eh || lo !== el || done !== edone) begin
            fails++;
            $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h done=%b expected hi=%h lo=%h done=%b",
                     o, a, b, hi, lo, done, eh, el, edone);
        end
        mh = eh;
        ml = el;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || hi !== mh || lo !== ml) begin
            fails++; $display("FAIL done_pulse op=%0d: got done=%b expected 0", o, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; v1 = '0; v2 = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
        end
        rst_n = 1'b1;
        mh = '0; ml = '0;
        run_op(3'd4, 32'h12345678, 32'h0);
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFFFFFE, 32'd3);
        tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            fails++; $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffa", hi, lo);
        end
        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        tests++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            fails++; $display("FAIL multu_const: got %h_%h expected 00000002_fffffffa", hi, lo);
        end
        run_op(3'd2, 32'hFFFFFFF9, 32'd2);
        tests++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            fails++; $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
        end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        tests++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            fails++; $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        run_op(3'd4, 32'hAAAA0000, 32'h0);
        run_op(3'd5, 32'h0000BBBB, 32'h0);
        run_op(3'd3, 32'h12345678, 32'h0);
        tests++;
        if (hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin
            fails++; $display("FAIL divu_zero: got %h_%h expected aaaa0000_0000bbbb", hi, lo);
        end
        run_op(3'd2, 32'h87654321, 32'h0);
    endtask

    task automatic test_start_while_busy();
        logic [31:0] eh, el;
        int nb;
        model(3'd0, 32'h00012345, 32'hFFFF0001, mh, ml, eh, el);
        @(negedge clk);
        start = 1'b1; op = 3'd0; v1 = 32'h00012345; v2 = 32'hFFFF0001;
        #1;
        tests++;
        if (accept !== 1'b1) begin
            fails++; $display("FAIL swb_issue: got accept=%b expected 1", accept);
        end
        @(negedge clk);
        op = 3'd5; v1 = 32'hDEAD; v2 = $urandom;
        nb = 0;
        while (busy === 1'b1 && nb < ML + 4) begin
            nb++;
            #1;
            tests++;
            if (accept !== 1'b0) begin
                fails++; $display("FAIL swb_accept cycle %0d: got %b expected 0", nb, accept);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (nb != ML || hi !== eh || lo !== el || done !== 1'b1 || accept !== 1'b1) begin
            fails++;
            $display("FAIL swb_commit: got busy_len=%0d hi=%h lo=%h done=%b accept=%b expected %0d %h %h 1 1",
                     nb, hi, lo, done, accept, ML, eh, el);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (lo !== 32'hDEAD || hi !== eh || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL swb_mtlo: got hi=%h lo=%h busy=%b done=%b expected %h 0000dead 0 0",
                     hi, lo, busy, done, eh);
        end
        mh = eh;
        ml = 32'hDEAD;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(o, a, b);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        run_op(3'd4, 32'h5555AAAA, 32'h0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; v1 = 32'd1000; v2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        mh = '0; ml = '0;
        stray = 0;
        for (int i = 0; i < DL + 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++; $display("FAIL late_commit: got %0d bad cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_while_busy();
        test_random();
        test_reset_mid();
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
